// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_encoding;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_encoding, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_encoding, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited requests to imem, in-order response queue,
// redirect flush with drop counting of in-flight responses.
module fetch_unit_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          enq_s,
  input logic          rsp_fire_s,
  input logic [CW-1:0] q_cnt_q,
  input logic [CW-1:0] out_cnt_q,
  input logic [31:0]   req_addr_s
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) enq_s |-> (q_cnt_q != DEPTH_C));
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n) rsp_fire_s |-> (out_cnt_q != {CW{1'b0}}));
  a_out_bound:   assert property (@(posedge clk) disable iff (!rst_n) out_cnt_q <= DEPTH_C);
  a_aligned:     assert property (@(posedge clk) disable iff (!rst_n) req_addr_s[1:0] == 2'b00);
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);
  localparam int unsigned   CW      = $clog2(DEPTH + 1);
  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          run_q;
  logic [CW-1:0] q_cnt_q, q_cnt_d, out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d, t_wr_q, t_wr_d, t_rd_q, t_rd_d;
  logic [31:0]   q_pc_q  [DEPTH];
  logic [31:0]   q_ins_q [DEPTH];
  logic [31:0]   tag_q   [DEPTH];
  logic          instr_valid_q, instr_valid_d;
  logic [31:0]   instr_pc_q, instr_pc_d, instr_enc_q, instr_enc_d;

  logic          req_valid_s, req_fire_s, rsp_fire_s, deq_fire_s, enq_s;
  logic [CW:0]   credit_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = pc_q;
  assign bus.instr_valid    = instr_valid_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_encoding = instr_enc_q;

  // Handshake events and the credit-limited request qualifier
  always_comb begin
    deq_fire_s  = instr_valid_q & bus.instr_ready;
    rsp_fire_s  = bus.imem_rsp_valid;
    credit_s    = {1'b0, q_cnt_q} + {1'b0, out_cnt_q} - (CW + 1)'(deq_fire_s);
    req_valid_s = run_q & ~bus.redirect_valid & (credit_s < DEPTH_C);
    req_fire_s  = req_valid_s & bus.imem_req_ready;
    enq_s       = rsp_fire_s & (drop_cnt_q == {CW{1'b0}}) & ~bus.redirect_valid;
  end

  // Next-state for pc, counters, pointers and the registered queue head
  always_comb begin
    out_cnt_d = out_cnt_q + CW'(req_fire_s) - CW'(rsp_fire_s);
    t_wr_d    = req_fire_s ? ptr_inc(t_wr_q) : t_wr_q;
    t_rd_d    = rsp_fire_s ? ptr_inc(t_rd_q) : t_rd_q;
    q_wr_d    = enq_s ? ptr_inc(q_wr_q) : q_wr_q;

    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc & 32'hFFFF_FFFC;
      q_cnt_d    = {CW{1'b0}};
      q_rd_d     = q_wr_q;
      // every request still outstanding after this edge belongs to the old path
      drop_cnt_d = out_cnt_d;
    end else begin
      pc_d       = req_fire_s ? (pc_q + 32'd4) : pc_q;
      q_cnt_d    = q_cnt_q + CW'(enq_s) - CW'(deq_fire_s);
      q_rd_d     = deq_fire_s ? ptr_inc(q_rd_q) : q_rd_q;
      if (rsp_fire_s && (drop_cnt_q != {CW{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end

    instr_valid_d = (q_cnt_d != {CW{1'b0}});
    // a response landing in an empty queue becomes the head directly
    if (enq_s && (q_wr_q == q_rd_d)) begin
      instr_pc_d  = tag_q[t_rd_q];
      instr_enc_d = bus.imem_rsp_data;
    end else begin
      instr_pc_d  = q_pc_q[q_rd_d];
      instr_enc_d = q_ins_q[q_rd_d];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      run_q         <= 1'b0;
      q_cnt_q       <= {CW{1'b0}};
      out_cnt_q     <= {CW{1'b0}};
      drop_cnt_q    <= {CW{1'b0}};
      q_wr_q        <= {PW{1'b0}};
      q_rd_q        <= {PW{1'b0}};
      t_wr_q        <= {PW{1'b0}};
      t_rd_q        <= {PW{1'b0}};
      instr_valid_q <= 1'b0;
      instr_pc_q    <= 32'h0000_0000;
      instr_enc_q   <= 32'h0000_0000;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]  <= 32'h0000_0000;
        q_ins_q[i] <= 32'h0000_0000;
        tag_q[i]   <= 32'h0000_0000;
      end
    end else begin
      pc_q          <= pc_d;
      run_q         <= 1'b1;
      q_cnt_q       <= q_cnt_d;
      out_cnt_q     <= out_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
      t_wr_q        <= t_wr_d;
      t_rd_q        <= t_rd_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
      instr_enc_q   <= instr_enc_d;
      if (enq_s) begin
        q_pc_q[q_wr_q]  <= tag_q[t_rd_q];
        q_ins_q[q_wr_q] <= bus.imem_rsp_data;
      end
      if (req_fire_s) begin
        tag_q[t_wr_q] <= pc_q;
      end
    end
  end

  fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_s      (enq_s),
    .rsp_fire_s (rsp_fire_s),
    .q_cnt_q    (q_cnt_q),
    .out_cnt_q  (out_cnt_q),
    .req_addr_s (pc_q)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model and an in-order pc scoreboard.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  logic rst2_n;

  fetch_unit_if bus1 ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut  (.clk(clk), .rst_n(rst_n),  .bus(bus1));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc, lat;
  logic        rand_rr, rand_ir, ir_hold;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_pc, exp_req, exp_pc2, exp_req2, last_deq_pc;
  int          fires1, deqs1, fires2;
  logic [31:0] addrs2[3];
  logic        seen_req, seen_valid;
  int          first_req_cyc, first_valid_cyc, occ_max;
  logic        pend2;
  logic [31:0] pend2_addr;
  logic        snap_rv, snap_iv;
  logic [31:0] snap_ra, snap_ipc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic rsp_due();
    return (mq_addr.size() > 0) && (mq_due[0] <= cyc);
  endfunction

  // One clock cycle: drive inputs, settle, score, advance to just after the next edge
  task automatic step(input logic redir, input logic [31:0] rpc);
    logic rsp1;
    int   occ;
    bus1.redirect_valid = redir;
    bus1.redirect_pc    = rpc;
    bus1.imem_req_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus1.instr_ready    = rand_ir ? 1'($urandom_range(0, 1)) : ir_hold;
    rsp1 = rsp_due();
    bus1.imem_rsp_valid = rsp1;
    bus1.imem_rsp_data  = rsp1 ? mem_word(mq_addr[0]) : 32'h0000_0000;
    bus2.imem_rsp_valid = pend2;
    bus2.imem_rsp_data  = pend2 ? mem_word(pend2_addr) : 32'h0000_0000;
    #1;
    snap_rv  = bus1.imem_req_valid;
    snap_ra  = bus1.imem_req_addr;
    snap_iv  = bus1.instr_valid;
    snap_ipc = bus1.instr_pc;
    if (redir) check("redir_noreq", 32'(bus1.imem_req_valid), 32'h0);
    if (bus1.imem_req_valid && bus1.imem_req_ready) begin
      check("req_addr", bus1.imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      mq_addr.push_back(bus1.imem_req_addr);
      mq_due.push_back(cyc + lat);
      fires1++;
      if (!seen_req) begin seen_req = 1'b1; first_req_cyc = cyc; end
    end
    if (rsp1) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (bus1.instr_valid && !seen_valid) begin seen_valid = 1'b1; first_valid_cyc = cyc; end
    if (bus1.instr_valid && bus1.instr_ready) begin
      check("deq_pc", bus1.instr_pc, exp_pc);
      check("deq_enc", bus1.instr_encoding, mem_word(exp_pc));
      last_deq_pc = bus1.instr_pc;
      exp_pc = exp_pc + 32'd4;
      deqs1++;
    end
    if (redir) begin
      exp_pc  = rpc & 32'hFFFF_FFFC;
      exp_req = rpc & 32'hFFFF_FFFC;
    end
    if (rst_n) begin
      occ = int'(u_dut.q_cnt_q) + int'(u_dut.out_cnt_q);
      if (occ > occ_max) occ_max = occ;
    end
    pend2 = bus2.imem_req_valid && bus2.imem_req_ready;
    pend2_addr = bus2.imem_req_addr;
    if (pend2) begin
      check("req2_addr", bus2.imem_req_addr, exp_req2);
      if (fires2 < 3) addrs2[fires2] = bus2.imem_req_addr;
      exp_req2 = exp_req2 + 32'd4;
      fires2++;
    end
    if (bus2.instr_valid && bus2.instr_ready) begin
      check("deq2_pc", bus2.instr_pc, exp_pc2);
      check("deq2_enc", bus2.instr_encoding, mem_word(exp_pc2));
      exp_pc2 = exp_pc2 + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b0; rst2_n = 1'b0;
    bus1.imem_req_ready = 1'b1; bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = 32'h0;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = 32'h0; bus1.instr_ready = 1'b0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = 32'h0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.instr_ready = 1'b1;
    lat = 1; rand_rr = 1'b0; rand_ir = 1'b0; ir_hold = 1'b0;
    exp_pc = 32'h0; exp_req = 32'h0; exp_pc2 = 32'hFFFF_FFF8; exp_req2 = 32'hFFFF_FFF8;
    fires1 = 0; deqs1 = 0; fires2 = 0; seen_req = 1'b0; seen_valid = 1'b0;
    first_req_cyc = 0; first_valid_cyc = 0; occ_max = 0; pend2 = 1'b0; pend2_addr = 32'h0;
    last_deq_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(bus1.imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(bus1.instr_valid), 32'h0);
    check("rst_instr_enc", bus1.instr_encoding, 32'h0);
    check("rst_instr_pc", bus1.instr_pc, 32'h0);
    check("rst_req_addr", bus1.imem_req_addr, 32'h0);

    // Reset release with decode stalled: two credits, then hold at pc 0
    rst_n = 1'b1; cyc = 0;
    step(1'b0, 32'h0);
    check("run_wait", 32'(snap_rv), 32'h0);
    step(1'b0, 32'h0);
    check("first_req_v", 32'(snap_rv), 32'h1);
    check("first_req_a", snap_ra, 32'h0);
    repeat (10) step(1'b0, 32'h0);
    check("stall_fires", 32'(fires1), 32'd2);
    check("stall_req_v", 32'(snap_rv), 32'h0);
    check("stall_iv", 32'(snap_iv), 32'h1);
    check("stall_ipc", snap_ipc, 32'h0);
    check("latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);

    // Release decode: one instruction per cycle with 1-cycle memory
    ir_hold = 1'b1;
    repeat (10) step(1'b0, 32'h0);
    d0 = deqs1;
    repeat (20) step(1'b0, 32'h0);
    check("throughput", 32'(deqs1 - d0), 32'd20);

    // 3-cycle memory, random request and decode backpressure
    lat = 3; rand_rr = 1'b1; rand_ir = 1'b1; occ_max = 0; d0 = deqs1;
    repeat (200) step(1'b0, 32'h0);
    check("occ_le_depth", 32'(occ_max <= 2), 32'h1);
    check("rand_progress", 32'(deqs1 > d0), 32'h1);

    // Redirect to 0x100 with two requests in flight
    rand_rr = 1'b0; rand_ir = 1'b0; ir_hold = 1'b1;
    n = 0;
    while (mq_addr.size() != 2 && n < 50) begin step(1'b0, 32'h0); n++; end
    check("d_inflight", 32'(mq_addr.size()), 32'd2);
    step(1'b1, 32'h0000_0100);
    check("d_drop_cnt", 32'(u_dut.drop_cnt_q), 32'(mq_addr.size()));
    step(1'b0, 32'h0);
    check("d_req_v", 32'(snap_rv), 32'h1);
    check("d_req_a", snap_ra, 32'h0000_0100);
    d0 = deqs1; n = 0;
    while (deqs1 == d0 && n < 30) begin step(1'b0, 32'h0); n++; end
    check("d_first_pc", last_deq_pc, 32'h0000_0100);

    // Redirect to unaligned 0x203 in the same cycle as a response
    n = 0;
    while (!rsp_due() && n < 30) begin step(1'b0, 32'h0); n++; end
    check("e_rsp_due", 32'(rsp_due()), 32'h1);
    step(1'b1, 32'h0000_0203);
    check("e_drop_cnt", 32'(u_dut.drop_cnt_q), 32'(mq_addr.size()));
    step(1'b0, 32'h0);
    check("e_req_v", 32'(snap_rv), 32'h1);
    check("e_req_a", snap_ra, 32'h0000_0200);
    d0 = deqs1; n = 0;
    while (deqs1 == d0 && n < 30) begin step(1'b0, 32'h0); n++; end
    check("e_first_pc", last_deq_pc, 32'h0000_0200);

    // Wrapping reset pc on the second instance, then asynchronous reset mid-stream
    rst_n = 1'b0; mq_addr.delete(); mq_due.delete();
    rst2_n = 1'b1;
    repeat (6) step(1'b0, 32'h0);
    check("wrap_fires", 32'(fires2 >= 3), 32'h1);
    check("wrap_a0", addrs2[0], 32'hFFFF_FFF8);
    check("wrap_a1", addrs2[1], 32'hFFFF_FFFC);
    check("wrap_a2", addrs2[2], 32'h0000_0000);
    check("wrap_pre_iv", 32'(bus2.instr_valid), 32'h1);
    #2;
    rst2_n = 1'b0;
    #1;
    check("arst_iv", 32'(bus2.instr_valid), 32'h0);
    check("arst_req_v", 32'(bus2.imem_req_valid), 32'h0);
    check("arst_pc", bus2.imem_req_addr, 32'hFFFF_FFF8);
    check("arst_ipc", bus2.instr_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
